// File: rtl/vga_draw_scheduler.sv
// Round-robin sharing of the vga_adapter pixel port among NUM_REQ drawing engines, with a full-screen clear engine.
// Optional burst timeout: define VGA_SCHED_TIMEOUT_EN to limit a grant to MAX_BURST cycles.
module vga_draw_scheduler #(
    parameter int         NUM_REQ      = 3,
    parameter int         SCREEN_W     = 320,
    parameter int         SCREEN_H     = 240,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000,
    parameter int         MAX_BURST    = 4096
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alarm_on,
    input  logic                 clear_start,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [9*NUM_REQ-1:0] req_x,
    input  logic [8*NUM_REQ-1:0] req_y,
    input  logic [3*NUM_REQ-1:0] req_colour,
    input  logic [NUM_REQ-1:0]   req_plot,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 clearing,
    output logic                 clear_done,
    output logic [8:0]           x,
    output logic [7:0]           y,
    output logic [2:0]           colour,
    output logic                 plot
);
    localparam int                 PTR_W    = $clog2(NUM_REQ);
    localparam logic [8:0]         X_LAST   = 9'(SCREEN_W - 1);
    localparam logic [7:0]         Y_LAST   = 8'(SCREEN_H - 1);
    localparam logic [PTR_W-1:0]   IDX_LAST = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W-1:0]   IDX_ZERO = {PTR_W{1'b0}};
    localparam logic [NUM_REQ-1:0] REQ_ZERO = {NUM_REQ{1'b0}};
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [PTR_W-1:0]   ptr_r, ptr_s, win_r, win_s, sel_s;
    logic               pend_r, pend_s, alarm_prev_r, clear_req_s, clear_last_s;
    logic [PTR_W:0]     pick_s;
    logic [NUM_REQ-1:0] avail_s, grant_r, grant_s;
    logic               clearing_r, clearing_s, clear_done_r, clear_done_s, plot_r, plot_s;
    logic [8:0]         x_r, x_s, cap_x_s;
    logic [7:0]         y_r, y_s, cap_y_s;
    logic [2:0]         colour_r, colour_s, cap_colour_s;
    logic               cap_plot_s, cap_req_s;
`ifdef VGA_SCHED_TIMEOUT_EN
    localparam int      CNT_W = $clog2(MAX_BURST + 1);
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [NUM_REQ-1:0] mask_r, mask_s;
`endif

    assign grant      = grant_r;
    assign clearing   = clearing_r;
    assign clear_done = clear_done_r;
    assign x          = x_r;
    assign y          = y_r;
    assign colour     = colour_r;
    assign plot       = plot_r;

    // Lowest offset from ptr (wrapping) among available requesters; MSB flags that one was found
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] avail,
                                               input logic [PTR_W-1:0]   ptr);
        logic [PTR_W:0]     res;
        logic [NUM_REQ-1:0] rot;
        int                 idx;
        res = {(PTR_W+1){1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            idx = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
            rot = avail >> idx;
            if (rot[0]) begin
                res = {1'b1, PTR_W'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Arbitration, requester data selection and next-state/output decode
    always_comb begin
        clear_req_s = clear_start | (alarm_on ^ alarm_prev_r);
`ifdef VGA_SCHED_TIMEOUT_EN
        avail_s = req & ~mask_r;
`else
        avail_s = req;
`endif
        pick_s       = rr_pick(avail_s, ptr_r);
        sel_s        = (state_r == ST_GRANT) ? win_r : pick_s[PTR_W-1:0];
        cap_req_s    = 1'(req >> sel_s);
        cap_plot_s   = 1'(req_plot >> sel_s);
        cap_x_s      = 9'(req_x >> (9 * int'(sel_s)));
        cap_y_s      = 8'(req_y >> (8 * int'(sel_s)));
        cap_colour_s = 3'(req_colour >> (3 * int'(sel_s)));
        clear_last_s = (x_r == X_LAST) && (y_r == Y_LAST);

        state_s      = state_r;
        ptr_s        = ptr_r;
        win_s        = win_r;
        pend_s       = pend_r;
        grant_s      = grant_r;
        clearing_s   = clearing_r;
        clear_done_s = 1'b0;
        plot_s       = 1'b0;
        x_s          = x_r;
        y_s          = y_r;
        colour_s     = colour_r;
`ifdef VGA_SCHED_TIMEOUT_EN
        cnt_s  = cnt_r;
        mask_s = mask_r & req;
`endif

        case (state_r)
            ST_IDLE: begin
                if (pend_r | clear_req_s) begin
                    state_s    = ST_CLEAR;
                    pend_s     = 1'b0;
                    clearing_s = 1'b1;
                    plot_s     = 1'b1;
                    x_s        = 9'd0;
                    y_s        = 8'd0;
                    colour_s   = CLEAR_COLOUR;
                end else if (pick_s[PTR_W]) begin
                    state_s  = ST_GRANT;
                    win_s    = pick_s[PTR_W-1:0];
                    grant_s  = ONE_HOT0 << pick_s[PTR_W-1:0];
                    plot_s   = cap_plot_s;
                    x_s      = cap_x_s;
                    y_s      = cap_y_s;
                    colour_s = cap_colour_s;
`ifdef VGA_SCHED_TIMEOUT_EN
                    cnt_s = CNT_W'(1'b1);
`endif
                end else begin
                    plot_s = 1'b0;
                end
            end
            ST_CLEAR: begin
                // A new clear request restarts the sweep instead of queueing another one
                if (clear_req_s) begin
                    plot_s   = 1'b1;
                    x_s      = 9'd0;
                    y_s      = 8'd0;
                    colour_s = CLEAR_COLOUR;
                end else if (clear_last_s) begin
                    state_s      = ST_IDLE;
                    clearing_s   = 1'b0;
                    clear_done_s = 1'b1;
                end else begin
                    plot_s   = 1'b1;
                    colour_s = CLEAR_COLOUR;
                    if (x_r == X_LAST) begin
                        x_s = 9'd0;
                        y_s = y_r + 8'd1;
                    end else begin
                        x_s = x_r + 9'd1;
                    end
                end
            end
            ST_GRANT: begin
                pend_s = pend_r | clear_req_s;
                if (!cap_req_s) begin
                    state_s = ST_IDLE;
                    grant_s = REQ_ZERO;
                    ptr_s   = (win_r == IDX_LAST) ? IDX_ZERO : win_r + PTR_W'(1'b1);
                end
`ifdef VGA_SCHED_TIMEOUT_EN
                else if (cnt_r == CNT_W'(MAX_BURST)) begin
                    state_s = ST_IDLE;
                    grant_s = REQ_ZERO;
                    ptr_s   = (win_r == IDX_LAST) ? IDX_ZERO : win_r + PTR_W'(1'b1);
                    mask_s  = mask_s | (ONE_HOT0 << win_r);
                end
`endif
                else begin
                    plot_s   = cap_plot_s;
                    x_s      = cap_x_s;
                    y_s      = cap_y_s;
                    colour_s = cap_colour_s;
`ifdef VGA_SCHED_TIMEOUT_EN
                    cnt_s = cnt_r + CNT_W'(1'b1);
`endif
                end
            end
            default: begin
                state_s    = ST_IDLE;
                grant_s    = REQ_ZERO;
                clearing_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs; the alarm history tracks alarm_on even through reset
    always_ff @(posedge clock) begin
        alarm_prev_r <= alarm_on;
        if (reset) begin
            state_r      <= ST_IDLE;
            ptr_r        <= IDX_ZERO;
            win_r        <= IDX_ZERO;
            pend_r       <= 1'b0;
            grant_r      <= REQ_ZERO;
            clearing_r   <= 1'b0;
            clear_done_r <= 1'b0;
            plot_r       <= 1'b0;
            x_r          <= 9'd0;
            y_r          <= 8'd0;
            colour_r     <= 3'd0;
`ifdef VGA_SCHED_TIMEOUT_EN
            cnt_r  <= {CNT_W{1'b0}};
            mask_r <= REQ_ZERO;
`endif
        end else begin
            state_r      <= state_s;
            ptr_r        <= ptr_s;
            win_r        <= win_s;
            pend_r       <= pend_s;
            grant_r      <= grant_s;
            clearing_r   <= clearing_s;
            clear_done_r <= clear_done_s;
            plot_r       <= plot_s;
            x_r          <= x_s;
            y_r          <= y_s;
            colour_r     <= colour_s;
`ifdef VGA_SCHED_TIMEOUT_EN
            cnt_r  <= cnt_s;
            mask_r <= mask_s;
`endif
        end
    end

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Bench for vga_draw_scheduler: a pixel-index model checked every cycle plus directed scenario checks.
// A small screen keeps full clear sweeps short; VGA_SCHED_TIMEOUT_EN adds the burst-timeout scenario.
module tb_vga_draw_scheduler;
    localparam int N = 3;
    localparam int W = 20;
    localparam int H = 6;
`ifdef VGA_SCHED_TIMEOUT_EN
    localparam int MB = 8;
    localparam bit TO = 1'b1;
`else
    localparam int MB = 4096;
    localparam bit TO = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset = 1'b1, alarm_on = 1'b1, clear_start = 1'b0;
    logic [N-1:0]   req = '0, req_plot = '0;
    logic [9*N-1:0] req_x = '0;
    logic [8*N-1:0] req_y = '0;
    logic [3*N-1:0] req_colour = '0;
    logic [N-1:0]   grant;
    logic           clearing, clear_done, plot;
    logic [8:0]     x;
    logic [7:0]     y;
    logic [2:0]     colour;

    int n_cmp = 0, n_bad = 0, cyc = 0;

    vga_draw_scheduler #(.NUM_REQ(N), .SCREEN_W(W), .SCREEN_H(H),
                         .CLEAR_COLOUR(3'b000), .MAX_BURST(MB)) dut (
        .clock(clock), .reset(reset), .alarm_on(alarm_on), .clear_start(clear_start),
        .req(req), .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_plot(req_plot),
        .grant(grant), .clearing(clearing), .clear_done(clear_done),
        .x(x), .y(y), .colour(colour), .plot(plot));

    always #5 clock = ~clock;

    // Model: mode 0 idle, 1 clearing (pixel index m_pix), 2 granted to m_win
    int m_mode = 0, m_ptr = 0, m_win = 0, m_pix = 0, m_cnt = 0;
    bit m_pend = 1'b0, m_prev = 1'b0, m_valid = 1'b0;
    bit [N-1:0] m_mask = '0;
    logic [N-1:0] e_grant = '0;
    logic e_clr = 1'b0, e_done = 1'b0, e_plot = 1'b0;
    logic [8:0] e_x = '0;
    logic [7:0] e_y = '0;
    logic [2:0] e_col = '0;

    function automatic void show_pixel();
        e_x = 9'(m_pix % W); e_y = 8'(m_pix / W); e_col = 3'b000; e_plot = 1'b1; e_clr = 1'b1;
    endfunction
    function automatic void take(int w);
        e_x = req_x[9*w +: 9]; e_y = req_y[8*w +: 8]; e_col = req_colour[3*w +: 3]; e_plot = req_plot[w];
    endfunction
    function automatic void drop_grant();
        e_grant = '0; e_plot = 1'b0; m_ptr = (m_win + 1) % N; m_mode = 0;
    endfunction

    always @(posedge clock) begin
        bit creq;
        bit [N-1:0] avail;
        int w;
        if (reset) begin
            m_mode = 0; m_ptr = 0; m_pend = 1'b0; m_prev = alarm_on; m_mask = '0;
            m_pix = 0; m_cnt = 0; m_win = 0; m_valid = 1'b1;
            e_grant = '0; e_clr = 1'b0; e_done = 1'b0; e_plot = 1'b0; e_x = '0; e_y = '0; e_col = '0;
        end else begin
            creq = clear_start || (alarm_on != m_prev);
            m_prev = alarm_on;
            e_done = 1'b0;
            m_mask = m_mask & req;
            case (m_mode)
                0: begin
                    avail = req & ~m_mask;
                    if (m_pend || creq) begin
                        m_pend = 1'b0; m_pix = 0; m_mode = 1; show_pixel();
                    end else if (avail != '0) begin
                        w = -1;
                        for (int k = 0; k < N; k++)
                            if (w < 0 && avail[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                        m_win = w; m_cnt = 1; m_mode = 2; e_grant = '0; e_grant[w] = 1'b1; take(w);
                    end else e_plot = 1'b0;
                end
                1: begin
                    if (creq) m_pix = 0; else m_pix++;
                    if (m_pix == W * H) begin
                        m_mode = 0; e_plot = 1'b0; e_clr = 1'b0; e_done = 1'b1;
                    end else show_pixel();
                end
                default: begin
                    m_pend = m_pend || creq;
                    if (!req[m_win]) drop_grant();
                    else if (TO && m_cnt == MB) begin drop_grant(); m_mask[m_win] = 1'b1; end
                    else begin take(m_win); m_cnt++; end
                end
            endcase
        end
    end

    // Scenario monitors, reset per scenario
    int clr_cyc, clr_plots, first_x, first_y, last_x, last_y, zero_hits, bad_col;
    int done_cnt, done_cyc, clr_start_cyc, g_plots, b2b;
    int g_cnt[N], first_g[N], last_g[N], hc[N];
    logic [N-1:0] prev_g;
    logic [N-1:0] order[$];
    bit rr_on = 1'b0;

    task automatic mon_clear();
        clr_cyc = 0; clr_plots = 0; first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        zero_hits = 0; bad_col = 0; done_cnt = 0; done_cyc = -1; clr_start_cyc = -1;
        g_plots = 0; b2b = 0; prev_g = '0; order.delete();
        for (int i = 0; i < N; i++) begin g_cnt[i] = 0; first_g[i] = -1; last_g[i] = -1; hc[i] = 0; end
    endtask

    task automatic chk(string name, int got, int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // One cycle: model comparison, monitors, reactive round-robin requesters
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (m_valid) begin
            n_cmp++;
            if ({grant, clearing, clear_done, plot, x, y, colour} !==
                {e_grant, e_clr, e_done, e_plot, e_x, e_y, e_col}) begin
                n_bad++;
                $display("FAIL outputs cyc=%0d: got g=%b clr=%b done=%b plot=%b x=%0d y=%0d c=%0d, expected g=%b clr=%b done=%b plot=%b x=%0d y=%0d c=%0d",
                         cyc, grant, clearing, clear_done, plot, x, y, colour,
                         e_grant, e_clr, e_done, e_plot, e_x, e_y, e_col);
            end
        end
        if (clearing) begin
            clr_cyc++;
            if (clr_start_cyc < 0) clr_start_cyc = cyc;
        end
        if (clearing && plot) begin
            if (clr_plots == 0) begin first_x = x; first_y = y; end
            last_x = x; last_y = y;
            if (x == 9'd0 && y == 8'd0) zero_hits++;
            if (colour != 3'd0) bad_col++;
            clr_plots++;
        end
        if (clear_done) begin done_cnt++; done_cyc = cyc; end
        if (grant != '0 && plot) g_plots++;
        for (int i = 0; i < N; i++)
            if (grant[i]) begin g_cnt[i]++; last_g[i] = cyc; if (first_g[i] < 0) first_g[i] = cyc; end
        if (grant != '0 && grant != prev_g) begin
            order.push_back(grant);
            if (prev_g != '0) b2b++;
        end
        prev_g = grant;
        if (rr_on) begin
            for (int i = 0; i < N; i++) begin
                req_x[9*i +: 9] = 9'((cyc * 3 + i * 40) % 300);
                if (grant[i]) begin
                    hc[i]++;
                    if (hc[i] == 4) begin req[i] = 1'b0; hc[i] = 0; end
                end else if (!req[i]) req[i] = 1'b1;
            end
        end
    endtask

    task automatic wait_done(string name, int limit);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin tick(); n++; end
        chk(name, (done_cnt > 0) ? 1 : 0, 1);
    endtask

    initial begin
        // Reset with alarm_on high: nothing may start
        mon_clear();
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("reset_plot", plot, 0);
        chk("reset_grant", grant, 0);
        chk("reset_x", x, 0);
        chk("reset_no_clear", clr_cyc, 0);
        chk("reset_no_done", done_cnt, 0);

        // Single burst on requester 1
        mon_clear();
        req_plot = 3'b010; req_y[15:8] = 8'd7; req_colour[5:3] = 3'b110;
        req[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_x[17:9] = 9'(5 + i);
            tick();
            if (i == 0) begin
                chk("burst_grant_latency", grant, 3'b010);
                chk("burst_first_x", x, 5);
            end
        end
        chk("burst_last_x", x, 14);
        req[1] = 1'b0;
        tick();
        chk("burst_grant_drop", grant, 0);
        chk("burst_plot_drop", plot, 0);
        chk("burst_len", g_cnt[1], 10);
        chk("burst_plots", g_plots, 10);

        // Round robin with all requesters cycling
        reset = 1'b1; tick(); reset = 1'b0;
        mon_clear();
        req_plot = 3'b111; req_y = {8'd30, 8'd20, 8'd10}; req_colour = {3'd3, 3'd2, 3'd1};
        req = 3'b111; rr_on = 1'b1;
        repeat (40) tick();
        rr_on = 1'b0; req = '0;
        repeat (3) tick();
        chk("rr_burst_count", (order.size() >= 6) ? 1 : 0, 1);
        for (int k = 0; k < 6; k++)
            chk($sformatf("rr_order%0d", k), (k < order.size()) ? int'(order[k]) : -1, 1 << (k % 3));
        chk("rr_no_back_to_back", b2b, 0);

        // Full clear from clear_start
        mon_clear();
        clear_start = 1'b1; tick(); clear_start = 1'b0;
        wait_done("clear_done_seen", 400);
        repeat (3) tick();
        chk("clear_plot_count", clr_plots, 120);
        chk("clear_first_xy", first_x * 256 + first_y, 0);
        chk("clear_last_xy", last_x * 256 + last_y, 19 * 256 + 5);
        chk("clear_colour", bad_col, 0);
        chk("clear_done_once", done_cnt, 1);

        // alarm_on toggle mid-burst, req[2] raised during the clear
        mon_clear();
        req_x[8:0] = 9'd50; req_plot = 3'b111;
        req[0] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 3) alarm_on = ~alarm_on;
            tick();
        end
        req[0] = 1'b0;
        repeat (20) tick();
        req[2] = 1'b1;
        begin
            int n = 0;
            while (first_g[2] < 0 && n < 400) begin tick(); n++; end
        end
        chk("alarm_burst_len", g_cnt[0], 9);
        chk("alarm_clear_after_idle", clr_start_cyc - last_g[0], 2);
        chk("alarm_clear_plots", clr_plots, 120);
        chk("alarm_req2_after_done", first_g[2] - done_cyc, 1);
        req[2] = 1'b0;
        repeat (3) tick();

        // Clear restarted by a second request mid-sweep
        mon_clear();
        clear_start = 1'b1; tick(); clear_start = 1'b0;
        begin
            int n = 0;
            while (clr_plots < 30 && n < 200) begin tick(); n++; end
        end
        clear_start = 1'b1; tick(); clear_start = 1'b0;
        wait_done("restart_done_seen", 400);
        repeat (2) tick();
        chk("restart_plot_count", clr_plots, 150);
        chk("restart_origin_hits", zero_hits, 2);
        chk("restart_done_once", done_cnt, 1);

        // Reset mid-clear aborts and drops the request
        mon_clear();
        clear_start = 1'b1; tick(); clear_start = 1'b0;
        repeat (10) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        mon_clear();
        repeat (10) tick();
        chk("abort_no_clear", clr_cyc, 0);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_plot", plot, 0);

`ifdef VGA_SCHED_TIMEOUT_EN
        // Timeout drops a held burst and masks the requester until it releases req
        reset = 1'b1; tick(); reset = 1'b0;
        mon_clear();
        req = 3'b011;
        repeat (12) tick();
        chk("timeout_len", g_cnt[0], 8);
        chk("timeout_next_grant", first_g[1] - last_g[0], 2);
        req[1] = 1'b0;
        repeat (6) tick();
        chk("timeout_masked", g_cnt[0], 8);
        req[0] = 1'b0; tick(); req[0] = 1'b1;
        repeat (3) tick();
        chk("timeout_regrant", grant, 3'b001);
        req = '0;
        repeat (2) tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
